// File: rtl/opcode_info_table.sv
// rtl/opcode_info_table.sv - writable multi-port opcode decode-info table
//
// Purpose:
//    Holds one INFO_W-bit decode word plus an entry-valid bit per {map, opcode}
//    and serves N_PORTS independent decoder lanes with a registered,
//    back-pressurable lookup. After reset an INIT sweep clears every entry,
//    one per cycle, before writes and lookups are accepted.
//
// Optional feature macro: OPINFO_PARITY_EN
//    When defined, each entry also stores an even-parity bit over {valid, info};
//    a lookup that sees a mismatch returns its data with rsp_perr set.
//    When undefined, rsp_perr is constant 0.
//
// Ports:
//    clk        in   1               clock
//    reset      in   1               synchronous, active-high reset
//    init_busy  out  1               clear sweep in progress
//    wr_valid   in   1               write request
//    wr_ready   out  1               write accepted when wr_valid && wr_ready
//    wr_addr    in   ADDR_W          {map, opcode} of entry to write
//    wr_info    in   INFO_W          decode word to store
//    wr_inval   in   1               clear the entry's valid bit instead
//    req_valid  in   N_PORTS         per-lane lookup request
//    req_ready  out  N_PORTS         per-lane request accept
//    req_addr   in   N_PORTS*ADDR_W  per-lane {map, opcode}
//    rsp_valid  out  N_PORTS         per-lane response valid
//    rsp_ready  in   N_PORTS         per-lane response consumed
//    rsp_info   out  N_PORTS*INFO_W  per-lane decode word (0 on miss)
//    rsp_miss   out  N_PORTS         entry was not valid
//    rsp_perr   out  N_PORTS         stored parity mismatch

module opcode_info_table #(
   parameter int N_PORTS = 2,
   parameter int MAP_W   = 1,
   parameter int INFO_W  = 23,
   localparam int ADDR_W = MAP_W + 8
) (
   input  logic                        clk,
   input  logic                        reset,
   output logic                        init_busy,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [INFO_W-1:0]           wr_info,
   input  logic                        wr_inval,
   input  logic [N_PORTS-1:0]          req_valid,
   output logic [N_PORTS-1:0]          req_ready,
   input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
   output logic [N_PORTS-1:0]          rsp_valid,
   input  logic [N_PORTS-1:0]          rsp_ready,
   output logic [N_PORTS*INFO_W-1:0]   rsp_info,
   output logic [N_PORTS-1:0]          rsp_miss,
   output logic [N_PORTS-1:0]          rsp_perr
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   init_cnt;
   logic                run;
   logic                wr_fire;
   logic [N_PORTS-1:0]  req_fire;

   // Bit INFO_W of each word is the entry-valid bit.
   logic [INFO_W:0]     mem [DEPTH];
`ifdef OPINFO_PARITY_EN
   logic                mem_par [DEPTH];
`endif

   logic                wr_en;
   logic [ADDR_W-1:0]   wr_a;
   logic [INFO_W:0]     wr_word;

   logic [ADDR_W-1:0]   lk_addr [N_PORTS];
   logic [INFO_W:0]     lk_word [N_PORTS];
   logic                lk_perr [N_PORTS];

   // State register and INIT sweep counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
         end
      end
   end

   // Next-state logic: leave INIT the cycle after the last entry is cleared.
   always_comb begin
      state_nxt = state;
      if (state == ST_INIT && init_cnt == ADDR_W'(DEPTH - 1)) begin
         state_nxt = ST_RUN;
      end
   end

   // Output logic. Readies are also gated by reset so nothing is handshaken
   // in a cycle whose effects are about to be discarded.
   always_comb begin
      run       = (state == ST_RUN) && !reset;
      init_busy = (state == ST_INIT);
      wr_ready  = run;
      for (int i = 0; i < N_PORTS; i++) begin
         req_ready[i] = run && (!rsp_valid[i] || rsp_ready[i]);
      end
   end

   assign wr_fire  = wr_valid && wr_ready;
   assign req_fire = req_valid & req_ready;

   // Single storage write port shared by the INIT sweep and the writer.
   // An invalidate stores an all-zero word; info under a clear valid bit
   // is never observable because a miss forces rsp_info to 0.
   always_comb begin
      if (state == ST_INIT) begin
         wr_en   = !reset;
         wr_a    = init_cnt;
         wr_word = '0;
      end else begin
         wr_en   = wr_fire;
         wr_a    = wr_addr;
         wr_word = wr_inval ? '0 : {1'b1, wr_info};
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_a] <= wr_word;
`ifdef OPINFO_PARITY_EN
         mem_par[wr_a] <= ^wr_word;
`endif
      end
   end

   // Per-lane lookup with write-first bypass. A bypassed word is fresh, so
   // it never reports a parity error.
   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         lk_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
         if (wr_fire && wr_addr == lk_addr[i]) begin
            lk_word[i] = wr_word;
            lk_perr[i] = 1'b0;
         end else begin
            lk_word[i] = mem[lk_addr[i]];
`ifdef OPINFO_PARITY_EN
            lk_perr[i] = ^{mem_par[lk_addr[i]], mem[lk_addr[i]]};
`else
            lk_perr[i] = 1'b0;
`endif
         end
      end
   end

   // Response registers: load on accept, hold under back-pressure.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_info  <= '0;
         rsp_miss  <= '0;
         rsp_perr  <= '0;
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (req_fire[i]) begin
               rsp_valid[i] <= 1'b1;
               rsp_miss[i]  <= !lk_word[i][INFO_W];
               rsp_info[i*INFO_W +: INFO_W] <= lk_word[i][INFO_W] ?
                                               lk_word[i][INFO_W-1:0] : '0;
               rsp_perr[i]  <= lk_perr[i];
            end else if (rsp_ready[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_opcode_info_table.sv
// tb/tb_opcode_info_table.sv - self-checking bench for opcode_info_table

module tb_opcode_info_table;

   localparam int NP    = 2;
   localparam int AW    = 9;
   localparam int IW    = 23;
   localparam int DEPTH = 512;

   logic               clk = 1'b0;
   logic               reset;
   logic               init_busy;
   logic               wr_valid;
   logic               wr_ready;
   logic [AW-1:0]      wr_addr;
   logic [IW-1:0]      wr_info;
   logic               wr_inval;
   logic [NP-1:0]      req_valid;
   logic [NP-1:0]      req_ready;
   logic [NP*AW-1:0]   req_addr;
   logic [NP-1:0]      rsp_valid;
   logic [NP-1:0]      rsp_ready;
   logic [NP*IW-1:0]   rsp_info;
   logic [NP-1:0]      rsp_miss;
   logic [NP-1:0]      rsp_perr;

   always #5 clk = ~clk;

   opcode_info_table #(.N_PORTS(NP), .MAP_W(1), .INFO_W(IW)) dut (
      .clk(clk), .reset(reset), .init_busy(init_busy),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_info(wr_info), .wr_inval(wr_inval),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_info(rsp_info),
      .rsp_miss(rsp_miss), .rsp_perr(rsp_perr)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: table contents, INIT progress, per-lane pending response.
   bit            m_v [DEPTH];
   logic [IW-1:0] m_i [DEPTH];
   bit            m_p [DEPTH];
   bit            m_busy;
   int            m_cnt;
   bit            e_v [NP];
   logic [IW-1:0] e_i [NP];
   bit            e_m [NP];
   bit            e_p [NP];

   task automatic model_step();
      logic [AW-1:0] a;
      if (reset) begin
         m_busy = 1'b1;
         m_cnt  = 0;
         for (int i = 0; i < NP; i++) begin
            e_v[i] = 1'b0; e_i[i] = '0; e_m[i] = 1'b0; e_p[i] = 1'b0;
         end
      end else if (m_busy) begin
         m_v[m_cnt] = 1'b0; m_i[m_cnt] = '0; m_p[m_cnt] = 1'b0;
         m_cnt++;
         if (m_cnt == DEPTH) m_busy = 1'b0;
      end else begin
         // write-first: apply the write, then serve the lookups
         if (wr_valid) begin
            m_v[wr_addr] = !wr_inval;
            m_i[wr_addr] = wr_info;
            m_p[wr_addr] = 1'b0;
         end
         for (int i = 0; i < NP; i++) begin
            a = req_addr[i*AW +: AW];
            if (req_valid[i] && (!e_v[i] || rsp_ready[i])) begin
               e_v[i] = 1'b1;
               e_m[i] = !m_v[a];
               e_i[i] = m_v[a] ? m_i[a] : '0;
               e_p[i] = m_p[a];
            end else if (rsp_ready[i]) begin
               e_v[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic compare();
      check("init_busy", 32'(init_busy), 32'(m_busy));
      if (!reset) begin
         check("wr_ready", 32'(wr_ready), 32'(!m_busy));
         for (int i = 0; i < NP; i++)
            check($sformatf("req_ready%0d", i), 32'(req_ready[i]),
                  32'(!m_busy && (!e_v[i] || rsp_ready[i])));
      end
      for (int i = 0; i < NP; i++) begin
         check($sformatf("rsp_valid%0d", i), 32'(rsp_valid[i]), 32'(e_v[i]));
         if (e_v[i]) begin
            check($sformatf("rsp_info%0d", i), 32'(rsp_info[i*IW +: IW]), 32'(e_i[i]));
            check($sformatf("rsp_miss%0d", i), 32'(rsp_miss[i]), 32'(e_m[i]));
            check($sformatf("rsp_perr%0d", i), 32'(rsp_perr[i]), 32'(e_p[i]));
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic idle();
      reset     = 1'b0;
      wr_valid  = 1'b0;
      wr_inval  = 1'b0;
      req_valid = '0;
      rsp_ready = '1;
   endtask

   task automatic set_req(input int lane, input logic [AW-1:0] a);
      req_addr[lane*AW +: AW] = a;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [IW-1:0] d, input logic inv);
      wr_valid = 1'b1; wr_addr = a; wr_info = d; wr_inval = inv;
   endtask

   // Steps until INIT ends, returning the number of busy cycles seen.
   task automatic run_init(output int n);
      n = 0;
      while (init_busy && n < 600) begin
         n++;
         step();
      end
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
      return AW'($urandom_range(0, 7));
   endfunction

   int n;

   initial begin
      idle();
      reset    = 1'b1;
      wr_addr  = '0;
      wr_info  = '0;
      req_addr = '0;
      step();
      for (int i = 0; i < NP; i++) begin
         check("rst_info", 32'(rsp_info[i*IW +: IW]), 32'd0);
         check("rst_miss", 32'(rsp_miss[i]), 32'd0);
         check("rst_perr", 32'(rsp_perr[i]), 32'd0);
      end
      step();

      // 1: INIT length with requests held, then read of an empty entry
      reset     = 1'b0;
      req_valid = '1;
      run_init(n);
      check("init_len", 32'(n), 32'd512);
      step();
      check("t1_valid", 32'(rsp_valid[0]), 32'd1);
      check("t1_miss", 32'(rsp_miss[0]), 32'd1);
      check("t1_info", 32'(rsp_info[0 +: IW]), 32'd0);

      // 2: write then read the next cycle
      idle();
      do_write(9'h001, 23'h4F0000, 1'b0);
      step();
      wr_valid  = 1'b0;
      req_valid = 2'b01;
      set_req(0, 9'h001);
      step();
      check("t2_valid", 32'(rsp_valid[0]), 32'd1);
      check("t2_info", 32'(rsp_info[0 +: IW]), 32'h4F0000);
      check("t2_miss", 32'(rsp_miss[0]), 32'd0);

      // 3: same-cycle write/read bypass, then same-cycle invalidate/read
      idle();
      do_write(9'h0B8, 23'h45E000, 1'b0);
      req_valid = 2'b10;
      set_req(1, 9'h0B8);
      step();
      check("t3_info", 32'(rsp_info[IW +: IW]), 32'h45E000);
      check("t3_miss", 32'(rsp_miss[1]), 32'd0);
      do_write(9'h0B8, 23'h45E000, 1'b1);
      step();
      check("t3_inv_miss", 32'(rsp_miss[1]), 32'd1);
      check("t3_inv_info", 32'(rsp_info[IW +: IW]), 32'd0);

      // 4: lane 0 stalled while lane 1 streams
      idle();
      for (int k = 0; k < 5; k++) begin
         do_write(AW'(9'h050 + k), IW'($urandom), 1'b0);
         step();
      end
      idle();
      req_valid = 2'b01;
      set_req(0, 9'h001);
      rsp_ready = 2'b10;
      step();
      req_valid = 2'b11;
      for (int k = 0; k < 5; k++) begin
         set_req(1, AW'(9'h050 + k));
         step();
         check("t4_req_ready0", 32'(req_ready[0]), 32'd0);
         check("t4_held_info", 32'(rsp_info[0 +: IW]), 32'h4F0000);
         check("t4_lane1_valid", 32'(rsp_valid[1]), 32'd1);
      end

      // 5: reset mid-INIT and in RUN with both responses pending
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 0; k < 100; k++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      run_init(n);
      check("t5_init_len", 32'(n), 32'd512);
      req_valid = 2'b11;
      set_req(0, 9'h0B8);
      set_req(1, 9'h0B8);
      rsp_ready = 2'b00;
      step();
      check("t5_both_valid", 32'(rsp_valid), 32'd3);
      req_valid = 2'b00;
      reset     = 1'b1;
      step();
      check("t5_rst_valid", 32'(rsp_valid), 32'd0);
      idle();
      run_init(n);
      check("t5_init_len2", 32'(n), 32'd512);
      req_valid = 2'b01;
      set_req(0, 9'h001);
      step();
      check("t5_old_miss", 32'(rsp_miss[0]), 32'd1);

`ifdef OPINFO_PARITY_EN
      // 6: injected stored-bit error, then cleared by rewrite
      idle();
      do_write(9'h0C6, 23'h123456, 1'b0);
      step();
      wr_valid = 1'b0;
      dut.mem[9'h0C6][4] = ~dut.mem[9'h0C6][4];
      m_i[9'h0C6][4]     = ~m_i[9'h0C6][4];
      m_p[9'h0C6]        = 1'b1;
      req_valid = 2'b01;
      set_req(0, 9'h0C6);
      step();
      check("t6_perr", 32'(rsp_perr[0]), 32'd1);
      req_valid = 2'b00;
      do_write(9'h0C6, 23'h123456, 1'b0);
      step();
      wr_valid  = 1'b0;
      req_valid = 2'b01;
      step();
      check("t6_perr_clr", 32'(rsp_perr[0]), 32'd0);
`endif

      // Random traffic over a small address pool to provoke collisions
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 999) == 0);
         wr_valid  = ($urandom_range(0, 2) == 0);
         wr_inval  = ($urandom_range(0, 3) == 0);
         wr_addr   = rnd_addr();
         wr_info   = IW'($urandom);
         req_valid = NP'($urandom);
         rsp_ready = NP'($urandom);
         for (int i = 0; i < NP; i++) set_req(i, rnd_addr());
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
